imem_fetch_arbiter: RTL and testbench

//   Controller for the shared single-port instruction memory feeding the uP.

---
 rtl/imem_fetch_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter
//
// Controller for the shared single-port instruction memory feeding the uP.
// Two requesters share the port: the CPU fetch path (reads at pc_next) and the
// program loader (writes). After reset the block sits in BOOT and only the
// loader is served. The handshake carrying ld_last moves the block to RUN,
// where fetches and loader writes are arbitrated with a bounded loader burst.
// Every cycle the CPU receives either a registered instruction word or a NOP
// bubble.
//
// State table:
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_BOOT | loader only; every fetch stalls; ld_valid & ld_last -> ST_RUN
//   ST_RUN  | one grant per cycle; loader limited to MAX_BURST grants while
//           | a fetch is waiting; left only through reset
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fetch_req, pc_next  CPU fetch request and address
//   instr, instr_vld    registered instruction word; vld=0 marks a NOP bubble
//   stall               fetch_req present but not granted this cycle (comb)
//   ld_valid, ld_ready  loader write handshake (ready is comb)
//   ld_addr, ld_data    loader write address and data
//   ld_last             marks the final loader word; ends BOOT
//   ld_err              sticky flag: an out-of-range loader write was dropped
//   boot_done           high in RUN
//   mem_en, mem_we,
//   mem_addr, mem_wdata memory port command (comb)
//   mem_rdata           read data, valid one cycle after a read command
// -----------------------------------------------------------------------------
module imem_fetch_arbiter #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 6,
  parameter int                DEPTH     = 62,
  parameter logic [DATA_W-1:0] NOP       = '0,
  parameter int                MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [DATA_W-1:0] instr,
  output logic              instr_vld,
  output logic              stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_err,
  output logic              boot_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter must be able to hold MAX_BURST itself.
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            rd_pend_q;
  logic [DATA_W-1:0] instr_q;
  logic            instr_vld_q;
  logic            ld_err_q;

  logic            ld_grant;
  logic            fetch_grant;
  logic            fetch_in_range;
  logic            ld_in_range;
  logic            burst_room;

  assign fetch_in_range = (32'(pc_next) < 32'(DEPTH));
  assign ld_in_range    = (32'(ld_addr) < 32'(DEPTH));
  assign burst_room     = (32'(burst_cnt_q) < 32'(MAX_BURST));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    ld_grant    = 1'b0;
    fetch_grant = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        ld_grant    = ld_valid;
        burst_cnt_d = '0;
        // The last word is still written in this cycle; RUN starts next edge.
        if (ld_valid && ld_last) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Loader keeps priority only while it has burst budget left; once
        // the budget is spent the waiting fetch takes the next slot.
        ld_grant    = ld_valid && (!fetch_req || burst_room);
        fetch_grant = fetch_req && !ld_grant;
        if (!fetch_req || fetch_grant) begin
          burst_cnt_d = '0;
        end else if (ld_grant) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d     = ST_BOOT;
        burst_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port command. Out-of-range requests are granted (consumed) but never
  // reach the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (ld_grant) begin
      if (ld_in_range) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
      end
    end else if (fetch_grant) begin
      if (fetch_in_range) begin
        mem_en   = 1'b1;
        mem_addr = pc_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path. rd_pend marks that the memory is presenting read data
  // this cycle; the word is registered on the following edge. Anything else,
  // including an out-of-range fetch, produces a NOP bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      instr_q     <= NOP;
      instr_vld_q <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      rd_pend_q   <= fetch_grant && fetch_in_range;
      instr_q     <= rd_pend_q ? mem_rdata : NOP;
      instr_vld_q <= rd_pend_q;
      if (ld_grant && !ld_in_range) begin
        ld_err_q <= 1'b1;
      end
    end
  end

  assign instr     = instr_q;
  assign instr_vld = instr_vld_q;
  assign ld_err    = ld_err_q;
  assign ld_ready  = ld_grant;
  assign stall     = fetch_req && !fetch_grant;
  assign boot_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for imem_fetch_arbiter. A behavioural synchronous SRAM
// (read data one cycle after the read command) sits on the memory port.
// Inputs change 1ns after a rising edge; outputs are checked before the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_imem_fetch_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] instr;
  logic              instr_vld;
  logic              stall;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_err;
  logic              boot_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [64];

  int tests_run    = 0;
  int tests_failed = 0;

  imem_fetch_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .pc_next   (pc_next),
    .instr     (instr),
    .instr_vld (instr_vld),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_err    (ld_err),
    .boot_done (boot_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0;
    pc_next   = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_last   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (instr !== 16'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0000", instr); end
    tests_run++;
    if (instr_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_vld got %b want 0", instr_vld); end
    tests_run++;
    if (boot_done !== 1'b0) begin tests_failed++; $display("FAIL reset_boot_done got %b want 0", boot_done); end
    tests_run++;
    if (ld_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ld_err got %b want 0", ld_err); end
    tests_run++;
    if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_boot();
    logic [DATA_W-1:0] words [3];
    words[0] = 16'hA001; words[1] = 16'hB002; words[2] = 16'hC003;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1;
      pc_next   = 6'd0;
      ld_valid  = 1'b1;
      ld_addr   = 6'(i);
      ld_data   = words[i];
      ld_last   = (i == 2);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin tests_failed++; $display("FAIL boot_stall[%0d] got %b want 1", i, stall); end
      tests_run++;
      if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL boot_ld_ready[%0d] got %b want 1", i, ld_ready); end
      tests_run++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'(i), words[i]})
        begin tests_failed++; $display("FAIL boot_mem_cmd[%0d] got en=%b we=%b a=%0d d=%h want 1 1 %0d %h",
          i, mem_en, mem_we, mem_addr, mem_wdata, i, words[i]); end
      tests_run++;
      if (boot_done !== 1'b0) begin tests_failed++; $display("FAIL boot_done_early[%0d] got %b want 0", i, boot_done); end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++;
    if (boot_done !== 1'b1) begin tests_failed++; $display("FAIL boot_done got %b want 1", boot_done); end
    tick();
  endtask

  task automatic test_fetch();
    logic [DATA_W-1:0] exp_w [5];
    logic              exp_v [5];
    exp_w[0] = 16'hA001; exp_w[1] = 16'hB002; exp_w[2] = 16'hC003; exp_w[3] = 16'h0; exp_w[4] = 16'h0;
    exp_v[0] = 1'b1;     exp_v[1] = 1'b1;     exp_v[2] = 1'b1;     exp_v[3] = 1'b0;  exp_v[4] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      fetch_req = (i < 3);
      pc_next   = 6'(i % 3);
      #1;
      if (i < 3) begin
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL fetch_stall[%0d] got %b want 0", i, stall); end
        tests_run++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 6'(i)})
          begin tests_failed++; $display("FAIL fetch_mem_cmd[%0d] got en=%b we=%b a=%0d want 1 0 %0d", i, mem_en, mem_we, mem_addr, i); end
      end
      tick();
      // Grant in cycle k returns its word after the edge closing cycle k+1.
      if (i >= 1) begin
        tests_run++;
        if ({instr_vld, instr} !== {exp_v[i-1], exp_w[i-1]})
          begin tests_failed++; $display("FAIL fetch_instr[%0d] got vld=%b %h want vld=%b %h", i-1, instr_vld, instr, exp_v[i-1], exp_w[i-1]); end
      end
    end
  endtask

  task automatic test_fairness();
    logic exp_rdy;
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      fetch_req = 1'b1;
      pc_next   = 6'd1;
      ld_valid  = 1'b1;
      ld_addr   = 6'd10;
      ld_data   = 16'(16'h1000 + i);
      ld_last   = 1'b1;
      exp_rdy   = ((i % 5) != 4);
      #1;
      tests_run++;
      if (ld_ready !== exp_rdy) begin tests_failed++; $display("FAIL fair_ld_ready[%0d] got %b want %b", i, ld_ready, exp_rdy); end
      tests_run++;
      if (stall !== exp_rdy) begin tests_failed++; $display("FAIL fair_stall[%0d] got %b want %b", i, stall, exp_rdy); end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++;
    if (boot_done !== 1'b1) begin tests_failed++; $display("FAIL run_ld_last_ignored got %b want 1", boot_done); end
    tick();
    tick();
  endtask

  task automatic test_write_then_read();
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 16'h1234;
    tick();
    idle_inputs();
    fetch_req = 1'b1; pc_next = 6'd5;
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if ({instr_vld, instr} !== {1'b1, 16'h1234})
      begin tests_failed++; $display("FAIL wr_then_rd got vld=%b %h want vld=1 1234", instr_vld, instr); end
    // Same-address collision: loader wins first, fetch then sees the new word.
    fetch_req = 1'b1; pc_next = 6'd5;
    ld_valid = 1'b1; ld_addr = 6'd5; ld_data = 16'h5555;
    #1;
    tests_run++;
    if ({ld_ready, stall} !== 2'b11) begin tests_failed++; $display("FAIL collide_grant got rdy=%b stall=%b want 1 1", ld_ready, stall); end
    tick();
    ld_valid = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL collide_fetch_stall got %b want 0", stall); end
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if ({instr_vld, instr} !== {1'b1, 16'h5555})
      begin tests_failed++; $display("FAIL collide_read got vld=%b %h want vld=1 5555", instr_vld, instr); end
  endtask

  task automatic test_range();
    idle_inputs();
    fetch_req = 1'b1; pc_next = 6'd0;
    tick();
    pc_next = 6'd62;
    #1;
    tests_run++;
    if ({stall, mem_en} !== 2'b00) begin tests_failed++; $display("FAIL range_fetch got stall=%b en=%b want 0 0", stall, mem_en); end
    tick();
    idle_inputs();
    tests_run++;
    if ({instr_vld, instr} !== {1'b1, 16'hA001})
      begin tests_failed++; $display("FAIL range_prev_word got vld=%b %h want vld=1 a001", instr_vld, instr); end
    tick();
    tests_run++;
    if ({instr_vld, instr} !== {1'b0, 16'h0})
      begin tests_failed++; $display("FAIL range_nop got vld=%b %h want vld=0 0000", instr_vld, instr); end
    ld_valid = 1'b1; ld_addr = 6'd63; ld_data = 16'hBEEF;
    #1;
    tests_run++;
    if ({ld_ready, mem_en, mem_we} !== 3'b100)
      begin tests_failed++; $display("FAIL range_ld_cmd got rdy=%b en=%b we=%b want 1 0 0", ld_ready, mem_en, mem_we); end
    tick();
    idle_inputs();
    tests_run++;
    if (ld_err !== 1'b1) begin tests_failed++; $display("FAIL range_ld_err got %b want 1", ld_err); end
    tick();
    tests_run++;
    if (ld_err !== 1'b1) begin tests_failed++; $display("FAIL range_ld_err_sticky got %b want 1", ld_err); end
    tests_run++;
    if (mem[63] !== 16'hDEAD) begin tests_failed++; $display("FAIL range_mem63 got %h want dead", mem[63]); end
  endtask

  task automatic test_reset_mid_run();
    idle_inputs();
    fetch_req = 1'b1; pc_next = 6'd1;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({instr_vld, instr, boot_done, ld_err} !== {1'b0, 16'h0, 1'b0, 1'b0})
      begin tests_failed++; $display("FAIL midrst_outputs got vld=%b %h boot=%b err=%b want 0 0000 0 0", instr_vld, instr, boot_done, ld_err); end
    #2;
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({instr_vld, instr} !== {1'b0, 16'h0})
      begin tests_failed++; $display("FAIL midrst_no_data got vld=%b %h want vld=0 0000", instr_vld, instr); end
    for (int i = 0; i < 2; i++) begin
      fetch_req = 1'b1; pc_next = 6'd2;
      #1;
      tests_run++;
      if ({stall, mem_en} !== 2'b10) begin tests_failed++; $display("FAIL midrst_stall[%0d] got stall=%b en=%b want 1 0", i, stall, mem_en); end
      tick();
    end
    ld_valid = 1'b1; ld_addr = 6'd3; ld_data = 16'hD004; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    tests_run++;
    if ({boot_done, stall} !== 2'b10) begin tests_failed++; $display("FAIL midrst_reboot got boot=%b stall=%b want 1 0", boot_done, stall); end
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if ({instr_vld, instr} !== {1'b1, 16'hC003})
      begin tests_failed++; $display("FAIL midrst_fetch got vld=%b %h want vld=1 c003", instr_vld, instr); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_boot();
    test_fetch();
    test_fairness();
    test_write_then_read();
    test_range();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
